// File: rtl/fft_out_serializer.sv
// fft_out_serializer: once per frame, reads the 8 complex bins from the FFT
// output register file (optionally in bit-reversed address order, which gives
// natural-order bins) and streams them out one per cycle on valid/ready with
// a last flag. A 2-entry buffer covers the 1-cycle read latency and downstream
// stalls, so with out_ready held high the 8 samples leave back to back.
//
// state  | meaning
// IDLE   | waiting for start; nothing issued, buffer empty
// STREAM | issuing reads and draining the buffer until the 8th handshake
module fft_out_serializer #(
    parameter int DW      = 32,
    parameter bit BIT_REV = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic [2:0]      rf_addr,
    output logic            rf_re,
    input  logic [2*DW-1:0] rf_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   out_data_r,
    output logic [DW-1:0]   out_data_i,
    output logic            out_last,
    output logic            busy,
    output logic            frame_done
);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    rd_cnt_q, rd_cnt_d;
    logic [2:0]    sent_cnt_q, sent_cnt_d;
    logic          infl_q, infl_d;
    logic [2:0]    addr_hold_q, addr_hold_d;
    logic [1:0]    occ_q, occ_d;
    logic [DW-1:0] ent0_r_q, ent0_r_d, ent0_i_q, ent0_i_d;
    logic [DW-1:0] ent1_r_q, ent1_r_d, ent1_i_q, ent1_i_d;
    logic          frame_done_q, frame_done_d;

    logic          pop;
    logic          push;
    logic [2:0]    level;
    logic [2:0]    addr_cur;
    logic [DW-1:0] push_r, push_i;

    // Read issue: only when the buffer plus the in-flight read still leaves room
    // after this cycle's pop. rf_addr repeats the last issued address when idle.
    always_comb begin
        pop      = (occ_q != 2'd0) & out_ready;
        push     = infl_q;
        push_r   = rf_data[2*DW-1:DW];
        push_i   = rf_data[DW-1:0];
        level    = {1'b0, occ_q} + {2'b00, infl_q} - {2'b00, pop};
        addr_cur = rd_cnt_q[2:0];
        if (BIT_REV) begin
            addr_cur = {rd_cnt_q[0], rd_cnt_q[1], rd_cnt_q[2]};
        end
        rf_re       = (state_q == STREAM) && (rd_cnt_q < 4'd8) && (level < 3'd2);
        rf_addr     = rf_re ? addr_cur : addr_hold_q;
        addr_hold_d = rf_re ? addr_cur : addr_hold_q;
        infl_d      = rf_re;
    end

    // Frame sequencing: read/handshake counters and the end-of-frame pulse.
    always_comb begin
        state_d      = state_q;
        rd_cnt_d     = rd_cnt_q;
        sent_cnt_d   = sent_cnt_q;
        frame_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = STREAM;
                    rd_cnt_d   = 4'd0;
                    sent_cnt_d = 3'd0;
                end
            end
            STREAM: begin
                if (rf_re) begin
                    rd_cnt_d = rd_cnt_q + 4'd1;
                end
                if (pop) begin
                    sent_cnt_d = sent_cnt_q + 3'd1;
                    if (sent_cnt_q == 3'd7) begin
                        state_d      = IDLE;
                        frame_done_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Two-entry buffer: entry 0 is the head and drives the outputs directly.
    // The issue rule guarantees a push never arrives while full without a pop.
    always_comb begin
        ent0_r_d = ent0_r_q;
        ent0_i_d = ent0_i_q;
        ent1_r_d = ent1_r_q;
        ent1_i_d = ent1_i_q;
        occ_d    = occ_q;
        case ({push, pop})
            2'b10: begin
                if (occ_q == 2'd0) begin
                    ent0_r_d = push_r;
                    ent0_i_d = push_i;
                end else begin
                    ent1_r_d = push_r;
                    ent1_i_d = push_i;
                end
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                ent0_r_d = ent1_r_q;
                ent0_i_d = ent1_i_q;
                occ_d    = occ_q - 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    ent0_r_d = push_r;
                    ent0_i_d = push_i;
                end else begin
                    ent0_r_d = ent1_r_q;
                    ent0_i_d = ent1_i_q;
                    ent1_r_d = push_r;
                    ent1_i_d = push_i;
                end
            end
            default: occ_d = occ_q;
        endcase
    end

    // State and datapath registers; reset discards any partial frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rd_cnt_q     <= 4'd0;
            sent_cnt_q   <= 3'd0;
            infl_q       <= 1'b0;
            addr_hold_q  <= 3'd0;
            occ_q        <= 2'd0;
            ent0_r_q     <= '0;
            ent0_i_q     <= '0;
            ent1_r_q     <= '0;
            ent1_i_q     <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rd_cnt_q     <= rd_cnt_d;
            sent_cnt_q   <= sent_cnt_d;
            infl_q       <= infl_d;
            addr_hold_q  <= addr_hold_d;
            occ_q        <= occ_d;
            ent0_r_q     <= ent0_r_d;
            ent0_i_q     <= ent0_i_d;
            ent1_r_q     <= ent1_r_d;
            ent1_i_q     <= ent1_i_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign out_valid  = (occ_q != 2'd0);
    assign out_data_r = ent0_r_q;
    assign out_data_i = ent0_i_q;
    assign out_last   = out_valid & (sent_cnt_q == 3'd7);
    assign busy       = (state_q == STREAM);
    assign frame_done = frame_done_q;

endmodule
